dac8568_frame_receiver: RTL and testbench

//  Receives DAC8568-format serial frames (SYNC/SCLK/DIN, as driven by our bitbang DAC transmitters).

---
 rtl/dac8568_frame_receiver.sv | 174 +++++++++++++++++
 tb/tb_dac8568_frame_receiver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dac8568_frame_receiver.sv
// DAC8568 serial frame receiver: synchronizes SYNC/SCLK/DIN, deserializes 32-bit frames
// and holds each complete word on a valid/ready output with framing/overflow reporting.
module dac8568_frame_receiver #(
  parameter int unsigned FRAME_BITS   = 32,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned ERRCNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sclk,
  input  logic                    sync_n,
  input  logic                    din,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic [31:0]             word,
  output logic [3:0]              prefix,
  output logic [3:0]              control,
  output logic [3:0]              address,
  output logic [15:0]             value,
  output logic [3:0]              feature,
  output logic                    frame_err,
  output logic                    overflow,
  output logic                    overflow_sticky,
  output logic [ERRCNT_WIDTH-1:0] err_count,
  input  logic                    clear_sticky,
  output logic                    busy
);

  typedef enum logic [1:0] {ARM, IDLE, SHIFT} state_t;

  localparam logic [5:0]  CNT_FULL = 6'(FRAME_BITS);
  localparam logic [5:0]  CNT_SAT  = 6'(FRAME_BITS + 1);
  localparam int unsigned SETTLE   = SYNC_STAGES + 2;
  localparam int unsigned ACW      = $clog2(SETTLE + 1);

  logic [SYNC_STAGES-1:0] sclk_sq, syncn_sq, din_sq;
  logic                   sclk_s, syncn_s, din_s;
  logic                   sclk_prev_q, syncn_prev_q;
  logic                   sclk_fall_q, sync_fall_q, sync_rise_q, din_q, syncn_lvl_q;

  state_t                  state_q;
  logic [ACW-1:0]          arm_cnt_q;
  logic [5:0]              cnt_q, cnt_d;
  logic [31:0]             shift_q, shift_d;
  logic [31:0]             word_q;
  logic                    word_valid_q, frame_err_q, overflow_q, sticky_q, busy_q;
  logic [ERRCNT_WIDTH-1:0] err_count_q;
  logic                    load_ok;

  assign sclk_s  = sclk_sq[SYNC_STAGES-1];
  assign syncn_s = syncn_sq[SYNC_STAGES-1];
  assign din_s   = din_sq[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sq  <= '0;
      syncn_sq <= '1;
      din_sq   <= '0;
    end else begin
      sclk_sq  <= {sclk_sq[SYNC_STAGES-2:0], sclk};
      syncn_sq <= {syncn_sq[SYNC_STAGES-2:0], sync_n};
      din_sq   <= {din_sq[SYNC_STAGES-2:0], din};
    end
  end

  // Edge strobes are registered together with din so bit and edge stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_q  <= 1'b0;
      syncn_prev_q <= 1'b1;
      sclk_fall_q  <= 1'b0;
      sync_fall_q  <= 1'b0;
      sync_rise_q  <= 1'b0;
      din_q        <= 1'b0;
      syncn_lvl_q  <= 1'b1;
    end else begin
      sclk_prev_q  <= sclk_s;
      syncn_prev_q <= syncn_s;
      sclk_fall_q  <= sclk_prev_q & ~sclk_s;
      sync_fall_q  <= syncn_prev_q & ~syncn_s;
      sync_rise_q  <= ~syncn_prev_q & syncn_s;
      din_q        <= din_s;
      syncn_lvl_q  <= syncn_s;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (sclk_fall_q) begin
      shift_d = {shift_q[30:0], din_q};
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 6'd1;
    end
    load_ok = ~word_valid_q | word_ready;
  end

  // ARM waits for the synchronizer pipeline to flush reset values before trusting sync_n.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARM;
      arm_cnt_q    <= '0;
      cnt_q        <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      sticky_q     <= 1'b0;
      err_count_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      if (word_valid_q && word_ready) word_valid_q <= 1'b0;
      if (clear_sticky) begin
        sticky_q    <= 1'b0;
        err_count_q <= '0;
      end
      case (state_q)
        ARM: begin
          if (arm_cnt_q != ACW'(SETTLE)) arm_cnt_q <= arm_cnt_q + ACW'(1);
          else if (syncn_lvl_q)          state_q   <= IDLE;
        end
        IDLE: begin
          if (sync_fall_q) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            shift_q <= '0;
          end
        end
        SHIFT: begin
          cnt_q   <= cnt_d;
          shift_q <= shift_d;
          if (sync_rise_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (cnt_d == CNT_FULL) begin
              if (load_ok) begin
                word_q       <= shift_d;
                word_valid_q <= 1'b1;
              end else begin
                overflow_q <= 1'b1;
                sticky_q   <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              if (clear_sticky)           err_count_q <= ERRCNT_WIDTH'(1);
              else if (err_count_q != '1) err_count_q <= err_count_q + ERRCNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state_q <= ARM;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign word_valid      = word_valid_q;
  assign word            = word_q;
  assign prefix          = word_q[31:28];
  assign control         = word_q[27:24];
  assign address         = word_q[23:20];
  assign value           = word_q[19:4];
  assign feature         = word_q[3:0];
  assign frame_err       = frame_err_q;
  assign overflow        = overflow_q;
  assign overflow_sticky = sticky_q;
  assign err_count       = err_count_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_dac8568_frame_receiver.sv
// Directed bench for dac8568_frame_receiver: bit-banged frames, expected values worked by hand.
module tb_dac8568_frame_receiver;

  logic        clk = 1'b0;
  logic        rst, sclk, sync_n, din, word_ready, clear_sticky;
  logic        word_valid, frame_err, overflow, overflow_sticky, busy;
  logic [31:0] word;
  logic [3:0]  prefix, control, address, feature;
  logic [15:0] value;
  logic [15:0] err_count;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vrise_cnt = 0;
  logic vprev = 1'b0;
  logic [31:0] got[$];
  int lat;
  int fe0, v0;

  always #5 clk = ~clk;

  dac8568_frame_receiver #(
    .FRAME_BITS(32),
    .SYNC_STAGES(2),
    .ERRCNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sync_n(sync_n), .din(din),
    .word_valid(word_valid), .word_ready(word_ready), .word(word),
    .prefix(prefix), .control(control), .address(address), .value(value), .feature(feature),
    .frame_err(frame_err), .overflow(overflow), .overflow_sticky(overflow_sticky),
    .err_count(err_count), .clear_sticky(clear_sticky), .busy(busy)
  );

  // Event monitor: sampled mid-cycle, where the DUT's next posedge sees the same values.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overflow) ov_cnt++;
    if (word_valid && !vprev) vrise_cnt++;
    if (word_valid && word_ready) got.push_back(word);
    vprev = word_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sbit(input logic b);
    din  = b;
    sclk = 1'b1;
    tick(3);
    sclk = 1'b0;
    tick(3);
  endtask

  // lat = cycles from the sync_n pin rise until word_valid first seen high (0 = never)
  task automatic send_frame(input logic [31:0] data, input int nbits, input bit coincide,
                            input int gap, output int latency);
    logic b;
    sync_n = 1'b0;
    tick(3);
    for (int i = 0; i < nbits; i++) begin
      b = (i < 32) ? data[31-i] : 1'b0;
      if (coincide && i == nbits - 1) begin
        din  = b;
        sclk = 1'b1;
        tick(3);
        sclk   = 1'b0;
        sync_n = 1'b1;
      end else begin
        sbit(b);
      end
    end
    sync_n  = 1'b1;
    latency = 0;
    for (int k = 1; k <= gap; k++) begin
      tick(1);
      if (latency == 0 && word_valid) latency = k;
    end
  endtask

  function automatic logic [31:0] got_at(input int idx);
    return (idx < got.size()) ? got[idx] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    rst = 1'b1; sclk = 1'b0; sync_n = 1'b1; din = 1'b0;
    word_ready = 1'b1; clear_sticky = 1'b0;
    tick(3);
    check("rst_valid", {31'b0, word_valid}, 32'd0);
    check("rst_word", word, 32'h0);
    check("rst_errcnt", {16'b0, err_count}, 32'd0);
    check("rst_busy_sticky", {30'b0, busy, overflow_sticky}, 32'd0);
    rst = 1'b0;
    tick(10);

    // 1: single frame, ready high
    send_frame(32'h0300_8000, 32, 1'b0, 12, lat);
    check("t1_latency", lat, 32'd4);
    check("t1_valid_pulses", vrise_cnt, 32'd1);
    check("t1_word", got_at(0), 32'h0300_8000);
    check("t1_fields", {prefix, control, address, feature}, 32'h0000_0300);
    check("t1_value", {16'b0, value}, 32'h0000_0800);
    check("t1_frame_err", fe_cnt, 32'd0);

    // 2: overflow while a word is held
    word_ready = 1'b0;
    send_frame(32'h0312_3450, 32, 1'b0, 12, lat);
    send_frame(32'h03F0_0010, 32, 1'b0, 12, lat);
    check("t2_overflow_pulses", ov_cnt, 32'd1);
    check("t2_sticky", {31'b0, overflow_sticky}, 32'd1);
    check("t2_held_word", word, 32'h0312_3450);
    check("t2_held_valid", {31'b0, word_valid}, 32'd1);
    clear_sticky = 1'b1;
    tick(1);
    clear_sticky = 1'b0;
    tick(1);
    check("t2_sticky_cleared", {31'b0, overflow_sticky}, 32'd0);
    word_ready = 1'b1;
    tick(2);
    check("t2_drained_word", got_at(1), 32'h0312_3450);
    check("t2_valid_low", {31'b0, word_valid}, 32'd0);

    // 3: short, long and empty frames
    v0 = vrise_cnt;
    send_frame(32'h1234_5678, 31, 1'b0, 12, lat);
    send_frame(32'h1234_5678, 33, 1'b0, 12, lat);
    send_frame(32'h0, 0, 1'b0, 12, lat);
    check("t3_frame_err_pulses", fe_cnt, 32'd3);
    check("t3_err_count", {16'b0, err_count}, 32'd3);
    check("t3_no_valid", vrise_cnt - v0, 32'd0);
    clear_sticky = 1'b1;
    tick(1);
    clear_sticky = 1'b0;
    tick(1);
    check("t3_err_cleared", {16'b0, err_count}, 32'd0);

    // 4: reset mid-frame, released with sync_n still low
    fe0 = fe_cnt;
    v0  = vrise_cnt;
    sync_n = 1'b0;
    tick(3);
    for (int i = 0; i < 16; i++) sbit(1'b1);
    check("t4_busy_mid", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    tick(2);
    check("t4_busy_rst", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) sbit(1'b1);
    sync_n = 1'b1;
    tick(12);
    check("t4_no_frame_err", fe_cnt - fe0, 32'd0);
    check("t4_no_word", vrise_cnt - v0, 32'd0);
    check("t4_word_zero", word, 32'h0);
    send_frame(32'h0000_0001, 32, 1'b0, 12, lat);
    check("t4_next_word", got_at(2), 32'h0000_0001);

    // 5: last sclk fall coincident with sync rise
    send_frame(32'hC0FF_EE01, 32, 1'b1, 12, lat);
    check("t5_latency", lat, 32'd4);
    check("t5_word", got_at(3), 32'hC0FF_EE01);
    check("t5_no_frame_err", fe_cnt - fe0, 32'd0);

    // 6: back-to-back frames, 2 clk gap, ready held high
    send_frame(32'hA5A5_0001, 32, 1'b0, 2, lat);
    send_frame(32'h5A5A_0002, 32, 1'b0, 2, lat);
    send_frame(32'h1234_5678, 32, 1'b0, 2, lat);
    tick(12);
    check("t6_count", got.size(), 32'd7);
    check("t6_word0", got_at(4), 32'hA5A5_0001);
    check("t6_word1", got_at(5), 32'h5A5A_0002);
    check("t6_word2", got_at(6), 32'h1234_5678);
    check("t6_no_overflow", ov_cnt, 32'd1);
    check("t6_no_frame_err", fe_cnt - fe0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
